// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with IF/ID register and one-entry skid buffer
module if_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        skid_valid;
  logic [31:0] skid_inst;
  logic [31:0] skid_addr;
  logic        grant;
  logic        capture;
  logic        pending;
  logic        unused_jump_lsbs;

  // A request is held off while the skid is occupied and dropped outright on a redirect.
  assign ibus_req_o  = (state == REQ) && !skid_valid && !jump_en_i;
  assign ibus_addr_o = pc;
  assign grant       = ibus_req_o && ibus_gnt_i;
  // Only a response for a live (non-squashed) request is kept; a response in the jump cycle is dropped.
  assign capture     = (state == WAIT) && ibus_rvalid_i && !jump_en_i;
  // A response is still owed by the bus in these states.
  assign pending     = (state == WAIT) || (state == DROP);
  // Word alignment: target low bits never reach the PC.
  assign unused_jump_lsbs = ^jump_addr_i[1:0];

  // Fetch FSM, PC and the address tag of the outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_ADDR;
      req_addr <= RESET_ADDR;
    end else if (jump_en_i) begin
      pc    <= {jump_addr_i[31:2], 2'b00};
      state <= (pending && !ibus_rvalid_i) ? DROP : REQ;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (grant) begin
            pc       <= pc + 32'd4;
            req_addr <= pc;
            state    <= WAIT;
          end
        end
        WAIT, DROP: begin
          if (ibus_rvalid_i) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // IF/ID register and skid buffer: a response that lands during a stall parks in the skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= 32'h0;
      inst_valid_o <= 1'b0;
      skid_valid   <= 1'b0;
      skid_inst    <= NOP_INST;
      skid_addr    <= 32'h0;
    end else if (jump_en_i) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      skid_valid   <= 1'b0;
    end else if (!hold_i) begin
      if (skid_valid) begin
        inst_o       <= skid_inst;
        inst_addr_o  <= skid_addr;
        inst_valid_o <= 1'b1;
        skid_valid   <= 1'b0;
      end else if (capture) begin
        inst_o       <= ibus_rdata_i;
        inst_addr_o  <= req_addr;
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP_INST;
        inst_valid_o <= 1'b0;
      end
    end else if (capture) begin
      skid_inst  <= ibus_rdata_i;
      skid_addr  <= req_addr;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized scoreboard bench for if_fetch
module tb_if_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RST2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_i = 1'b0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic [31:0] inst2;
  logic [31:0] iaddr2;
  logic        ival2;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc = 32'h0;
  logic        last_hold = 1'b0;
  logic        last_jump = 1'b0;
  logic        pending = 1'b0;
  int          wait_left = 0;
  logic [31:0] pend_addr = 32'h0;
  logic        prev_req_stall = 1'b0;
  logic [31:0] prev_req_addr = 32'h0;
  logic [31:0] dut2_grants[$];
  logic [31:0] prev_inst = NOP;
  logic [31:0] prev_addr = 32'h0;
  logic        prev_valid = 1'b0;

  if_fetch dut (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_i(hold_i), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  if_fetch #(.RESET_ADDR(RST2)) dut2 (
    .clk(clk), .rst_n(rst_n), .jump_en_i(1'b0), .jump_addr_i(32'h0),
    .hold_i(1'b0), .ibus_req_o(req2), .ibus_addr_o(addr2),
    .ibus_gnt_i(1'b1), .ibus_rvalid_i(rvalid2), .ibus_rdata_i(rdata2),
    .inst_o(inst2), .inst_addr_o(iaddr2), .inst_valid_o(ival2)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: observe the cycle at negedge, then update model, bus and next inputs.
  task automatic step(input logic hold, input logic jump, input logic [31:0] jaddr,
                      input int gnt_pct, input int max_lat);
    logic        s_req, s_gnt, s_rvalid, s_hold, s_jump, s_grant2;
    logic [31:0] s_addr, s_jaddr, s_addr2;
    @(negedge clk);
    s_req    = ibus_req_o;
    s_gnt    = ibus_gnt_i;
    s_addr   = ibus_addr_o;
    s_rvalid = ibus_rvalid_i;
    s_hold   = hold_i;
    s_jump   = jump_en_i;
    s_jaddr  = jump_addr_i;
    s_grant2 = req2;
    s_addr2  = addr2;
    if (prev_req_stall && !s_jump) begin
      chk("req_not_withdrawn", 32'(s_req), 32'd1);
      chk("req_addr_stable", s_addr, prev_req_addr);
    end
    @(posedge clk);
    #1;
    if (s_req && s_gnt) begin
      chk("fetch_addr", s_addr, exp_pc);
      exp_q.push_back({exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end
    if (s_jump) begin
      exp_q.delete();
      exp_pc = {s_jaddr[31:2], 2'b00};
    end
    last_hold      = s_hold;
    last_jump      = s_jump;
    prev_req_stall = s_req && !s_gnt;
    prev_req_addr  = s_addr;
    ibus_rvalid_i  = 1'b0;
    ibus_rdata_i   = $urandom();
    if (s_rvalid) pending = 1'b0;
    if (s_req && s_gnt) begin
      pending   = 1'b1;
      pend_addr = s_addr;
      wait_left = int'($urandom_range(1, max_lat));
    end
    if (pending && wait_left > 0) begin
      wait_left--;
      if (wait_left == 0) begin
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = mem_word(pend_addr);
      end
    end
    rvalid2 = s_grant2;
    rdata2  = mem_word(s_addr2);
    if (s_grant2 && dut2_grants.size() < 3) dut2_grants.push_back(s_addr2);
    hold_i      = hold;
    jump_en_i   = jump;
    jump_addr_i = jump ? jaddr : $urandom();
    ibus_gnt_i  = int'($urandom_range(0, 99)) < gnt_pct;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    hold_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'h0; ibus_gnt_i = 1'b0;
    ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0; rvalid2 = 1'b0; rdata2 = 32'h0;
    pending = 1'b0; wait_left = 0; exp_q.delete(); exp_pc = 32'h0;
    last_hold = 1'b0; last_jump = 1'b0; prev_req_stall = 1'b0;
    #1;
    chk("rst_req", 32'(ibus_req_o), 32'd0);
    chk("rst_ibus_addr", ibus_addr_o, 32'h0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_inst_addr", inst_addr_o, 32'h0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int lat);
    for (int k = 0; k < 20 && !(ibus_req_o && ibus_gnt_i); k++) step(1'b0, 1'b0, 32'h0, 100, lat);
    n_checks++;
    if (!(ibus_req_o && ibus_gnt_i)) begin
      n_errors++;
      $display("FAIL grant_timeout: got no grant expected grant within 20 cycles");
    end
  endtask

  // Monitor: every IF/ID load with valid set must deliver the next surviving fetch in order.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n) begin
      if (last_jump) begin
        chk("jump_valid", 32'(inst_valid_o), 32'd0);
      end else if (last_hold) begin
        chk("hold_inst", inst_o, prev_inst);
        chk("hold_addr", inst_addr_o, prev_addr);
        chk("hold_valid", 32'(inst_valid_o), 32'(prev_valid));
      end else if (inst_valid_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL inst_unexpected: got addr %h data %h expected none", inst_addr_o, inst_o);
        end else begin
          e = exp_q.pop_front();
          chk("inst_addr", inst_addr_o, e[63:32]);
          chk("inst_data", inst_o, e[31:0]);
        end
      end
      if (!inst_valid_o) chk("nop_when_invalid", inst_o, NOP);
    end
    prev_inst  = inst_o;
    prev_addr  = inst_addr_o;
    prev_valid = inst_valid_o;
  end

  initial begin
    logic h, j;
    do_reset();
    // zero-wait free run: valid on cycles 4, 6, 8 after release with addresses 0, 4, 8
    for (int i = 1; i <= 8; i++) begin
      logic ev;
      step(1'b0, 1'b0, 32'h0, 100, 1);
      ev = (i == 3) || (i == 5) || (i == 7);
      chk("freerun_valid", 32'(inst_valid_o), 32'(ev));
      if (ev) chk("freerun_addr", inst_addr_o, 32'((i - 3) * 2));
    end
    // stall across a response, then release
    repeat (5) step(1'b1, 1'b0, 32'h0, 100, 1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 100, 1);
    // redirect while a response is outstanding
    wait_grant(3);
    step(1'b0, 1'b1, 32'h0000_0100, 100, 3);
    repeat (12) step(1'b0, 1'b0, 32'h0, 100, 3);
    // unaligned target
    wait_grant(2);
    step(1'b0, 1'b1, 32'h0000_0103, 100, 2);
    repeat (10) step(1'b0, 1'b0, 32'h0, 100, 2);
    // redirect during a stall with the skid full
    repeat (6) step(1'b1, 1'b0, 32'h0, 100, 1);
    step(1'b1, 1'b1, 32'h0000_0200, 100, 1);
    repeat (10) step(1'b0, 1'b0, 32'h0, 100, 1);
    // PC wrap-around
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 100, 1);
    repeat (10) step(1'b0, 1'b0, 32'h0, 100, 1);
    // random traffic, a mid-run reset, more random traffic
    for (int i = 0; i < 3000; i++) begin
      h = $urandom_range(0, 99) < 30;
      j = $urandom_range(0, 99) < 4;
      step(h, j, $urandom(), 60, int'($urandom_range(1, 4)));
    end
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      h = $urandom_range(0, 99) < 30;
      j = $urandom_range(0, 99) < 4;
      step(h, j, $urandom(), 60, int'($urandom_range(1, 4)));
    end
    // drain: no new grants, every surviving fetch must have been delivered
    repeat (40) step(1'b0, 1'b0, 32'h0, 0, 4);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("rst2_count", 32'(dut2_grants.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < dut2_grants.size()) chk("rst2_addr", dut2_grants[k], RST2 + 32'(4 * k));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage with built-in IF/ID pipeline register. Owns the PC, issues word fetches on a req/gnt/rvalid instruction bus, and presents `inst_o`/`inst_addr_o` to the decode stage (`id`), which consumes them combinationally. Handles jump redirects from execute, with in-flight response discard, and downstream stalls, with a one-entry skid buffer.

## Interface
- `RESET_ADDR`, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- `NOP_INST`, 32'h0000_0013, instruction word driven to decode when no valid instruction (`addi x0,x0,0`).

Ports:
- `clk`  in  1  Clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, asynchronous assert, active-low.
- `jump_en_i`  in  1  Redirect request from execute; single-cycle pulse.
- `jump_addr_i`  in  32  Redirect target; bits [1:0] ignored and treated as 0.
- `hold_i`  in  1  Stall from downstream; freezes the IF/ID register.
- `ibus_req_o`  out  1  Fetch request valid.
- `ibus_addr_o`  out  32  Fetch address; equals the PC.
- `ibus_gnt_i`  in  1  Request accepted this cycle (req && gnt).
- `ibus_rvalid_i`  in  1  Read data valid; exactly one per granted request, at least 1 cycle after gnt.
- `ibus_rdata_i`  in  32  Instruction word.
- `inst_o`  out  32  Instruction to decode.
- `inst_addr_o`  out  32  Address of `inst_o`.
- `inst_valid_o`  out  1  `inst_o` is a real fetched instruction.

## Operation
- FSM states:
  - IDLE (reset state): always goes to REQ the next cycle.
  - REQ: `ibus_req_o` = !skid_valid && !jump_en_i.
    - On req && gnt: PC += 4, go to WAIT.
  - WAIT: no request issued.
    - On rvalid: go to REQ.
  - DROP: no request issued.
    - On rvalid: data discarded, go to REQ.
- At most one request outstanding.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Captured response: a response in WAIT is tagged with the address that was granted, held in an internal register (`req_addr`).
- IF/ID register update when `hold_i`=0, in priority order:
  1. If skid_valid: load from skid.
  2. Else if a response is captured this cycle: load `ibus_rdata_i`, `req_addr`, valid = 1.
  3. Else: load `NOP_INST`, unchanged address, valid = 0.
- IF/ID register when `hold_i`=1: keeps its value. A response captured that cycle goes into the skid buffer (skid_valid <= 1).
- Skid buffer:
  - The skid is full only while `hold_i` is high.
  - While skid_valid is set, no new request is issued, so the skid cannot overflow.
- Jump (`jump_en_i`=1) overrides hold and every other update:
  - PC <= {`jump_addr_i`[31:2], 2'b00}.
  - IF/ID <= `NOP_INST`, valid 0; skid_valid <= 0.
  - `ibus_req_o` is forced to 0 this cycle.
  - Next state:
    - WAIT without rvalid this cycle, or DROP without rvalid: go to DROP (the old response is still pending).
    - Otherwise: go to REQ. A response arriving in the jump cycle itself is discarded.
- Jump while in DROP: PC is updated. The state stays DROP until the stale rvalid arrives.

## Timing
- Reset values (rst_n low):
  - PC = `RESET_ADDR`, state = IDLE.
  - `ibus_req_o` = 0, `ibus_addr_o` = `RESET_ADDR`.
  - `inst_o` = `NOP_INST`, `inst_addr_o` = 32'h0, `inst_valid_o` = 0, skid_valid = 0.
- First cycle after release: IDLE. First request is asserted in cycle 2.
- Latency with zero-wait memory (gnt in cycle N, rvalid in N+1): the instruction is visible on `inst_o` in cycle N+2.
- Steady-state throughput: one instruction per 2 cycles (REQ, WAIT).
- `ibus_addr_o` is stable while `ibus_req_o`=1 and gnt=0. A request is never withdrawn except by a jump.
- `inst_o`, `inst_addr_o` and `inst_valid_o` are registered. `ibus_req_o` is combinational from state, skid_valid and `jump_en_i`.
- Reset asserted mid-fetch: everything returns to reset values at once. An rvalid arriving after reset release while in IDLE or REQ is ignored. The bus is required to be reset together with this block.

## Test plan
- Reset then free run, zero-wait memory returning word = address: `inst_o`/`inst_addr_o` sequence 0, 4, 8, with `inst_valid_o`=1 on every second cycle, starting 4 cycles after release.
- `hold_i` high for 5 cycles while a response for addr 8 arrives: `inst_o` frozen, no request while the skid is full. On release, addr 8 appears next cycle and the request for 12 follows; no instruction is lost or duplicated.
- `jump_en_i` with `jump_addr_i`=32'h100 while in WAIT, with rvalid 3 cycles later: the stale response is dropped. `inst_o` = NOP, valid 0, until the instruction at 32'h100 appears. The next `ibus_addr_o` is 32'h100.
- Jump in the same cycle as `hold_i`=1 with the skid full: the skid is cleared, IF/ID holds NOP with valid 0, and fetch restarts at the target.
- `RESET_ADDR`=32'hFFFF_FFF8: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `jump_addr_i`=32'h0000_0103: fetch address is 32'h0000_0100.
